// File: rtl/uart_rx_param_pkg.sv
// Shared state encoding and parameter-legality limits for the UART receiver.
package uart_rx_param_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } rx_state_e;

    localparam int unsigned CLK_DIV_MIN    = 1;
    localparam int unsigned CLK_DIV_MAX    = 4095;
    localparam int unsigned OVERSAMPLE_REQ = 16;
    localparam int unsigned DATA_BITS_MIN  = 5;
    localparam int unsigned DATA_BITS_MAX  = 8;
    localparam int unsigned STOP_BITS_MIN  = 1;
    localparam int unsigned STOP_BITS_MAX  = 2;
    localparam int unsigned FIFO_DEPTH_MIN = 2;
    localparam int unsigned FIFO_DEPTH_MAX = 256;

    function automatic bit is_pow2(int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_param_fifo.sv
// Receive FIFO with show-ahead head; Full/Empty derive from the occupancy count.
module rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     WR,
    input  logic                     RD,
    input  logic [WIDTH-1:0]         Data_in,
    output logic [WIDTH-1:0]         Data_out,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             do_wr, do_rd;

    // A write into a full FIFO only proceeds when a pop frees the head slot in the same cycle.
    assign do_wr = WR && (!Full || RD);
    assign do_rd = RD && !Empty;

    assign Full     = (Count == (AW + 1)'(DEPTH));
    assign Empty    = (Count == '0);
    assign Data_out = Empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge Clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= Data_in;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            Count    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: synchronised RX, mid-bit sampling FSM, parity/framing checks,
// and a show-ahead receive FIFO with a sticky overrun flag.
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 27,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Enable,
    input  logic                          RX,
    input  logic                          RD,
    input  logic                          Err_clr,
    output logic [DATA_BITS-1:0]          Data_out,
    output logic                          Empty,
    output logic                          Full,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          FE,
    output logic                          PE,
    output logic                          OE,
    output logic                          Busy
);
    localparam logic [11:0] TICK_LAST = 12'(CLK_DIV - 1);
    localparam logic [3:0]  SUB_MID   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  SUB_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        PAR_INV   = (PARITY_ODD != 0);

    if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_clk_div
        $error("uart_rx_param: CLK_DIV must be in 1..4095");
    end
    if (OVERSAMPLE != OVERSAMPLE_REQ) begin : g_bad_oversample
        $error("uart_rx_param: OVERSAMPLE must be 16");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be in 5..8");
    end
    if (PARITY_EN > 1 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_rx_param: PARITY_EN and PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < FIFO_DEPTH_MIN || FIFO_DEPTH > FIFO_DEPTH_MAX || !is_pow2(FIFO_DEPTH))
    begin : g_bad_fifo_depth
        $error("uart_rx_param: FIFO_DEPTH must be a power of 2 in 2..256");
    end

    // Reset asserts immediately but releases only after two clean clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Bits [1:0] form the synchroniser; bit 2 keeps the previous rx_s for edge detection.
    logic [2:0] rx_sync_q;
    logic       rx_s, start_edge;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) rx_sync_q <= 3'b111;
        else        rx_sync_q <= {rx_sync_q[1:0], RX};
    end
    assign rx_s       = rx_sync_q[1];
    assign start_edge = rx_sync_q[2] & ~rx_s;

    rx_state_e            state_q;
    logic [11:0]          tick_cnt_q;
    logic [3:0]           sub_cnt_q;
    logic [2:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_fail_q, stop_err_q;
    logic                 tick, mid, last, frame_err, frame_ok, overrun;

    assign tick      = (tick_cnt_q == TICK_LAST);
    assign mid       = tick && (sub_cnt_q == SUB_MID);
    assign last      = tick && (sub_cnt_q == SUB_LAST);
    assign frame_err = stop_err_q | ~rx_s;
    assign frame_ok  = Enable && (state_q == StStop) && mid && (bit_cnt_q == STOP_LAST) &&
                       !frame_err && !par_fail_q;
    assign overrun   = frame_ok && Full && !RD;
    assign Busy      = (state_q != StIdle);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            sub_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_fail_q <= 1'b0;
            stop_err_q <= 1'b0;
            FE         <= 1'b0;
            PE         <= 1'b0;
        end else begin
            FE         <= 1'b0;
            PE         <= 1'b0;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 12'd1;
            if (tick && state_q != StIdle) sub_cnt_q <= sub_cnt_q + 4'd1;
            if (!Enable) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_edge) begin
                            state_q    <= StStart;
                            tick_cnt_q <= '0;
                            sub_cnt_q  <= '0;
                            bit_cnt_q  <= '0;
                            par_fail_q <= 1'b0;
                            stop_err_q <= 1'b0;
                        end
                    end
                    StStart: begin
                        if (mid && rx_s) state_q <= StIdle;
                        else if (last)   state_q <= StData;
                    end
                    StData: begin
                        if (mid) begin
                            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        end else if (last) begin
                            if (bit_cnt_q == DATA_LAST) begin
                                bit_cnt_q <= '0;
                                state_q   <= (PARITY_EN != 0) ? StParity : StStop;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    StParity: begin
                        if (mid && (rx_s != ((^shift_q) ^ PAR_INV))) par_fail_q <= 1'b1;
                        else if (last)                               state_q    <= StStop;
                    end
                    StStop: begin
                        // Decide at the last stop mid-sample so a back-to-back start is caught.
                        if (mid && bit_cnt_q == STOP_LAST) begin
                            FE      <= frame_err;
                            PE      <= !frame_err && par_fail_q;
                            state_q <= StIdle;
                        end else if (mid && !rx_s) begin
                            stop_err_q <= 1'b1;
                        end else if (last) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n)       OE <= 1'b0;
        else if (overrun) OE <= 1'b1;
        else if (Err_clr) OE <= 1'b0;
    end

    rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset_n  (rst_n),
        .WR       (frame_ok),
        .RD       (RD),
        .Data_in  (shift_q),
        .Data_out (Data_out),
        .Count    (Count),
        .Full     (Full),
        .Empty    (Empty)
    );

endmodule
